// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and line levels for the serial transmitter
package serial_tx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - free-running bit-period counter with a one-cycle wrap tick
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr,
   output logic wrap
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt;

   assign wrap = !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         cnt <= '0;
      else if (clr || wrap)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - framed parallel-to-serial transmitter (start, LSB-first data, parity, stop)
module serial_bit_tx
   import serial_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_line,
   output logic              busy,
   output logic              done
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t         state, state_next;
   logic              wrap;
   logic              accept;
   logic              last_stop;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic              parity_q, parity_next;
   logic              line_next;
   logic [IW-1:0]     bit_idx;
   logic              stop_idx;

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (state == IDLE),
      .wrap  (wrap)
   );

   assign last_stop = (state == STOP) && wrap && (stop_idx == STOP_LAST);
   assign accept    = tx_valid && tx_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = START;
         START:   if (wrap) state_next = DATA;
         DATA:    if (wrap && bit_idx == BIT_LAST)
                     state_next = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (wrap) state_next = STOP;
         STOP:    if (last_stop) state_next = accept ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ready in the final stop cycle lets the next frame start with no idle gap.
   always_comb begin
      tx_ready = rst_b && ((state == IDLE) || last_stop);
      busy     = (state != IDLE);
      done     = last_stop;
   end

   // The line is registered from the next state so it changes on the same edge as the FSM.
   always_comb begin
      shreg_next  = shreg;
      parity_next = parity_q;
      if (accept) begin
         shreg_next  = tx_data;
         parity_next = (^tx_data) ^ 1'(PARITY_ODD);
      end else if (state == DATA && wrap) begin
         shreg_next = shreg >> 1;
      end
      case (state_next)
         START:   line_next = START_BIT;
         DATA:    line_next = shreg_next[0];
         PARITY:  line_next = parity_next;
         default: line_next = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         shreg    <= '0;
         parity_q <= 1'b0;
         tx_line  <= LINE_IDLE;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
      end else begin
         shreg    <= shreg_next;
         parity_q <= parity_next;
         tx_line  <= line_next;
         if (state_next != state)
            bit_idx <= '0;
         else if (state == DATA && wrap)
            bit_idx <= bit_idx + 1'b1;
         if (state_next != state)
            stop_idx <= 1'b0;
         else if (state == STOP && wrap)
            stop_idx <= stop_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb/tb_serial_bit_tx.sv - directed bench for serial_bit_tx (default build plus a 1-clk/odd/2-stop build)
module tb_serial_bit_tx;

   logic       clk = 1'b0;
   logic       rst_b;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_line, busy, done;
   logic [7:0] tx_data6;
   logic       tx_valid6;
   logic       tx_ready6, tx_line6, busy6, done6;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_bit_tx u_dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_line  (tx_line),
      .busy     (busy),
      .done     (done)
   );

   serial_bit_tx #(
      .DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
   ) u_dut6 (
      .clk      (clk),
      .rst_b    (rst_b),
      .tx_data  (tx_data6),
      .tx_valid (tx_valid6),
      .tx_ready (tx_ready6),
      .tx_line  (tx_line6),
      .busy     (busy6),
      .done     (done6)
   );

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;   // bit i = serial bit i: stop, parity, data[7:0], start
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] d);
      int n = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready before send", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic check_frame(input logic [10:0] exp, input string tag);
      int         dones = 0;
      logic [3:0] s;
      for (int i = 0; i < 11; i++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            s[c] = tx_line;
            if (done) dones++;
            if (i == 10 && c == 3) begin
               chk($sformatf("%s done last cycle", tag), done, 1);
               chk($sformatf("%s ready last cycle", tag), tx_ready, 1);
            end
         end
         chk($sformatf("%s bit%0d", tag, i), s, {4{exp[i]}});
      end
      chk($sformatf("%s done count", tag), dones, 1);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk(tag, {tx_line, busy, tx_ready, done}, 4'b1010);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] obs, dn;

      vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
      vecs[1] = '{8'h01, 11'b1_1_00000001_0};
      vecs[2] = '{8'h80, 11'b1_1_10000000_0};
      vecs[3] = '{8'h7F, 11'b1_1_01111111_0};
      vecs[4] = '{8'hC3, 11'b1_0_11000011_0};

      rst_b = 1'b0; tx_data = '0; tx_valid = 1'b0; tx_data6 = '0; tx_valid6 = 1'b0;

      // reset hold
      repeat (3) begin
         @(negedge clk);
         chk("reset outputs", {tx_line, tx_ready, busy, done}, 4'b1000);
      end
      rst_b = 1'b1;
      #1 chk("ready after release", tx_ready, 1);

      // table of single frames
      for (int v = 0; v < 5; v++) begin
         start_frame(vecs[v].data);
         check_frame(vecs[v].bits, $sformatf("frame %02h", vecs[v].data));
         check_idle($sformatf("idle after %02h", vecs[v].data));
      end

      // back-to-back with tx_valid held high
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_data = 8'hFF;
      check_frame(11'b1_0_00000000_0, "b2b 00");
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check_frame(11'b1_0_11111111_0, "b2b FF");
      check_idle("idle after b2b");

      // tx_data changes right after accept
      start_frame(8'h12);
      tx_data = 8'hFF;
      check_frame(11'b1_0_00010010_0, "frame 12 data change");
      check_idle("idle after 12");

      // reset during data bit 3 of 0x3C
      start_frame(8'h3C);
      repeat (18) @(negedge clk);
      chk("3C bit3 before reset", tx_line, 1);
      chk("3C busy before reset", busy, 1);
      #2 rst_b = 1'b0;
      #1 chk("async reset outputs", {tx_line, busy, tx_ready, done}, 4'b1000);
      repeat (2) begin
         @(negedge clk);
         chk("held reset outputs", {tx_line, busy, tx_ready, done}, 4'b1000);
      end
      rst_b = 1'b1;
      #1 chk("ready after mid-frame reset", tx_ready, 1);
      start_frame(8'h81);
      check_frame(11'b1_0_10000001_0, "frame 81 after reset");
      check_idle("idle after 81");

      // 1 clk per bit, odd parity, two stop bits
      @(negedge clk);
      chk("dut6 ready", tx_ready6, 1);
      tx_data6  = 8'h01;
      tx_valid6 = 1'b1;
      @(posedge clk);
      #1 tx_valid6 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         obs[i] = tx_line6;
         dn[i]  = done6;
      end
      chk("dut6 line", obs, 12'b110000000010);
      chk("dut6 done", dn, 12'b100000000000);
      @(negedge clk);
      chk("dut6 idle", {tx_line6, busy6, tx_ready6, done6}, 4'b1010);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
